// File: rtl/demux_scan_ctrl.sv
// Scan sequencer driving a 1-to-8 demux: steps through the enabled channels in ascending order, DWELL cycles each.
// Latency: sel/busy follow an accepted start by one cycle; data_out is combinational from data_in (gated by busy).
// No backpressure: start is sampled only in IDLE, abort wins over everything. Optional macro SCAN_LOOP_EN = continuous wrap-around scanning.
module demux_scan_ctrl #(
  parameter int DWELL = 4,
  parameter int CW    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] mask,
  input  logic       data_in,
  output logic       data_out,
  output logic       sel1,
  output logic       sel2,
  output logic       sel3,
  output logic [2:0] ch,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [7:0]    r_mask;
  logic [7:0]    w_mask_nxt;
  logic [2:0]    r_ch;
  logic [2:0]    w_ch_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;

  logic [7:0]    w_above;
  logic          w_has_next;
  logic [2:0]    w_next_ch;
  logic [2:0]    w_first_ch;
  logic          w_dwell_end;

`ifdef SCAN_LOOP_EN
  logic          r_wrap;
  logic          w_wrap_nxt;
`endif

  // Index of the lowest set bit; returns 0 for an all-zero vector.
  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int k = 7; k >= 0; k--) begin
      if (v[k]) idx = 3'(k);
    end
    return idx;
  endfunction

  // Priority search: enabled channels strictly above the current one, lowest wins.
  always_comb begin
    w_above     = r_mask & ~((8'd2 << r_ch) - 8'd1);
    w_has_next  = |w_above;
    w_next_ch   = lowest_set(w_above);
    w_first_ch  = lowest_set(mask);
    w_dwell_end = (r_cnt == CW'(DWELL - 1));
  end

  // Next-state and datapath update; abort is checked first in every state.
  always_comb begin
    w_state_nxt = r_state;
    w_mask_nxt  = r_mask;
    w_ch_nxt    = r_ch;
    w_cnt_nxt   = r_cnt;
`ifdef SCAN_LOOP_EN
    w_wrap_nxt  = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (start) begin
          if (mask != 8'd0) begin
            w_mask_nxt  = mask;
            w_ch_nxt    = w_first_ch;
            w_cnt_nxt   = '0;
            w_state_nxt = ST_SCAN;
          end else begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_SCAN: begin
        if (abort) begin
          w_ch_nxt    = 3'd0;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end else if (w_dwell_end) begin
          w_cnt_nxt = '0;
          if (w_has_next) begin
            w_ch_nxt = w_next_ch;
          end else begin
`ifdef SCAN_LOOP_EN
            w_ch_nxt   = lowest_set(r_mask);
            w_wrap_nxt = 1'b1;
`else
            w_state_nxt = ST_DONE;
`endif
          end
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      ST_DONE: begin
        w_cnt_nxt   = '0;
        w_state_nxt = ST_IDLE;
        if (abort) w_ch_nxt = 3'd0;
      end
      default: begin
        w_ch_nxt    = 3'd0;
        w_cnt_nxt   = '0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, latched mask, channel and dwell counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_mask  <= 8'd0;
      r_ch    <= 3'd0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_mask  <= w_mask_nxt;
      r_ch    <= w_ch_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

`ifdef SCAN_LOOP_EN
  // Marks the first cycle of each repeated pass.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_wrap <= 1'b0;
    else        r_wrap <= w_wrap_nxt;
  end
`endif

  // Output decode: selects come straight from the channel register, data is gated by busy.
  always_comb begin
    busy     = (r_state == ST_SCAN);
    data_out = data_in & busy;
    ch       = r_ch;
    sel1     = r_ch[2];
    sel2     = r_ch[1];
    sel3     = r_ch[0];
`ifdef SCAN_LOOP_EN
    done     = (r_state == ST_DONE) | r_wrap;
`else
    done     = (r_state == ST_DONE);
`endif
  end

endmodule

// File: tb/tb_demux_scan_ctrl.sv
// Self-checking bench for demux_scan_ctrl (single-pass build, DWELL=4).
// Directed table of scan shapes, hand-written abort/reset sequences, then randomized scans against a schedule model.
// The model expands a mask into a per-cycle list of expected {busy, ch, done}.
module tb_demux_scan_ctrl;
  localparam int DWELL = 4;
  localparam int CW    = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] mask = 8'd0;
  logic       data_in = 1'b0;
  logic       data_out, sel1, sel2, sel3, busy, done;
  logic [2:0] ch;

  int n_cmp  = 0;
  int n_fail = 0;
  int m_ch   = 0;   // model of the held channel while idle

  typedef struct {
    logic       busy;
    logic [2:0] ch;
    logic       done;
  } exp_t;
  exp_t sched[$];

  typedef struct {
    logic [7:0] mask;
    int         busy_cycles;
    int         first_ch;
    int         last_ch;
    int         done_cyc;
    int         hold_ch;
  } vec_t;
  vec_t tbl[7];

  demux_scan_ctrl #(.DWELL(DWELL), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mask(mask),
    .data_in(data_in), .data_out(data_out), .sel1(sel1), .sel2(sel2),
    .sel3(sel3), .ch(ch), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, want, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " done"}, 32'(done), 0);
    chk({tag, " ch"}, 32'(ch), 32'(m_ch));
    chk({tag, " sel"}, 32'({sel1, sel2, sel3}), 32'(m_ch));
  endtask

  // Expected per-cycle behaviour after an accepted start with mask m.
  task automatic build_sched(input logic [7:0] m);
    int last;
    last = m_ch;
    sched.delete();
    for (int k = 0; k < 8; k++) begin
      if (m[k]) begin
        for (int d = 0; d < DWELL; d++) sched.push_back('{1'b1, 3'(k), 1'b0});
        last = k;
      end
    end
    sched.push_back('{1'b0, 3'(last), 1'b1});
  endtask

  // Start a scan in the current cycle and check every following cycle against the schedule.
  task automatic run_scan(input logic [7:0] m, input int abort_idx, input bit noisy);
    start = 1'b1;
    mask  = m;
    abort = 1'b0;
    step();
    start = 1'b0;
    build_sched(m);
    for (int j = 0; j < sched.size(); j++) begin
      data_in = 1'($urandom);
      if (noisy) begin
        mask  = 8'($urandom);
        start = 1'($urandom);
      end
      abort = (j == abort_idx);
      #1;
      chk("scan busy", 32'(busy), 32'(sched[j].busy));
      chk("scan ch", 32'(ch), 32'(sched[j].ch));
      chk("scan sel", 32'({sel1, sel2, sel3}), 32'(sched[j].ch));
      chk("scan done", 32'(done), 32'(sched[j].done));
      chk("scan data_out", 32'(data_out), 32'(data_in & sched[j].busy));
      if (j == abort_idx) begin
        step();
        abort = 1'b0;
        start = 1'b0;
        m_ch  = 0;
        chk_idle("post-abort");
        return;
      end
      step();
    end
    start = 1'b0;
    abort = 1'b0;
    m_ch  = sched[sched.size()-1].ch;
    chk_idle("post-scan");
  endtask

  initial begin
    int busy_n, done_n, done_at, first, last, len, ai;
    logic [7:0] m;

    tbl[0] = '{8'h00,  0, -1, -1,  1, 0};
    tbl[1] = '{8'h81,  8,  0,  7,  9, 7};
    tbl[2] = '{8'hFF, 32,  0,  7, 33, 7};
    tbl[3] = '{8'h24,  8,  2,  5,  9, 5};
    tbl[4] = '{8'h01,  4,  0,  0,  5, 0};
    tbl[5] = '{8'h80,  4,  7,  7,  5, 7};
    tbl[6] = '{8'h7E, 24,  1,  6, 25, 6};

    // Reset state, both while held and after release.
    data_in = 1'b1;
    #3;
    chk("rst busy", 32'(busy), 0);
    chk("rst done", 32'(done), 0);
    chk("rst ch", 32'(ch), 0);
    chk("rst data_out", 32'(data_out), 0);
    step();
    #2 rst_n = 1'b1;
    step();
    chk_idle("after reset");
    chk("idle data_out", 32'(data_out), 0);

    // Directed scan shapes.
    for (int i = 0; i < 7; i++) begin
      start = 1'b1;
      mask  = tbl[i].mask;
      step();
      start = 1'b0;
      mask  = 8'($urandom);
      busy_n = 0; done_n = 0; done_at = -1; first = -1; last = -1;
      for (int c = 1; c <= tbl[i].done_cyc + 1; c++) begin
        data_in = 1'($urandom);
        #1;
        chk("tbl data_out", 32'(data_out), 32'(data_in & (c <= tbl[i].busy_cycles)));
        if (busy) begin
          busy_n++;
          if (first < 0) first = ch;
          last = ch;
        end
        if (done) begin
          done_n++;
          if (done_at < 0) done_at = c;
        end
        step();
      end
      chk("tbl busy cycles", 32'(busy_n), 32'(tbl[i].busy_cycles));
      chk("tbl done cycle", 32'(done_at), 32'(tbl[i].done_cyc));
      chk("tbl done count", 32'(done_n), 1);
      chk("tbl first ch", 32'(first), 32'(tbl[i].first_ch));
      chk("tbl last ch", 32'(last), 32'(tbl[i].last_ch));
      chk("tbl hold ch", 32'(ch), 32'(tbl[i].hold_ch));
    end
    m_ch = 6;

    // Abort together with start in IDLE: start is dropped.
    start = 1'b1; abort = 1'b1; mask = 8'hFF;
    step();
    start = 1'b0; abort = 1'b0;
    chk_idle("abort+start");
    step();
    chk_idle("abort+start later");

    // Abort two cycles into a scan of 8'h24, then immediate restart.
    run_scan(8'h24, 2, 1'b0);
    run_scan(8'h81, -1, 1'b0);
    run_scan(8'h00, -1, 1'b0);

    // Asynchronous reset mid-scan.
    start = 1'b1; mask = 8'hFF;
    step();
    start = 1'b0;
    step(); step(); step();
    data_in = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    chk("arst busy", 32'(busy), 0);
    chk("arst done", 32'(done), 0);
    chk("arst data_out", 32'(data_out), 0);
    chk("arst sel", 32'({sel1, sel2, sel3}), 0);
    step();
    #2 rst_n = 1'b1;
    step();
    m_ch = 0;
    chk_idle("after arst");
    run_scan(8'h0C, -1, 1'b0);

    // Randomized scans with noisy inputs and occasional aborts.
    for (int it = 0; it < 40; it++) begin
      m = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
      len = $countones(m) * DWELL + 1;
      ai = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : -1;
      run_scan(m, ai, 1'b1);
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        mask = 8'($urandom);
        data_in = 1'($urandom);
        step();
        chk_idle("gap");
        chk("gap data_out", 32'(data_out), 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/demux_scan_ctrl.md
# demux_scan_ctrl

Sequencer that sits directly upstream of the 1-to-8 data demultiplexer and drives its data input and three select lines. On a start request it steps through the enabled channels in ascending order and holds each channel selected for a fixed dwell time. Only gated data reaches the demux, so every demux output stays low while the sequencer is idle. It reports progress through a busy/done handshake and supports abort.

## Interface
- `DWELL`, default 4: cycles each enabled channel stays selected; legal range 1..255.
- `CW`, default 8: dwell counter width; must satisfy 2^CW > DWELL.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `start` input 1: scan request, sampled only in IDLE.
- `abort` input 1: terminate scan; takes priority over every other event.
- `mask` input 8: channel enables; bit k enables demux output k+1. Latched on accepted start.
- `data_in` input 1: payload routed to the selected channel.
- `data_out` output 1: connects to demux `in1`; combinational `data_in & busy`.
- `sel1` output 1: select bit 2, the MSB; connects to demux `ins1`.
- `sel2` output 1: select bit 1; connects to demux `ins2`.
- `sel3` output 1: select bit 0; connects to demux `ins3`.
- `ch` output 3: current channel index, equal to {sel1,sel2,sel3}.
- `busy` output 1: high while in SCAN.
- `done` output 1: one-cycle pulse when a scan completes normally.

## Operation
- Reset values: state IDLE, sel1..3=0, ch=0, busy=0, done=0, data_out=0, mask register=0, dwell counter=0.
- State IDLE:
  - start=1 with mask≠0: latch mask, load ch with the lowest set bit index, clear the dwell counter, go to SCAN.
  - start=1 with mask=0: go to DONE with no scan.
- State SCAN:
  - Dwell counter increments each cycle.
  - When the counter reaches DWELL-1, advance to the next higher set bit of the latched mask and clear the counter.
  - Masked-off channels consume zero cycles.
  - After the highest set bit finishes its dwell, go to DONE.
- State DONE: done=1 for one cycle, then IDLE. sel holds its last value until the next accepted start.
- abort=1 in SCAN or DONE: go to IDLE next edge. No done pulse; sel and ch clear to 0.
- start during SCAN or DONE: ignored. Changes to `mask` while busy: ignored, because the latched copy is used.
- Simultaneous abort and start in IDLE: abort wins and start is dropped.
- Asynchronous reset mid-scan: all outputs go to reset values immediately; no done pulse.

## Timing
- start sampled high at edge T:
  - busy=1 and sel = first channel from T+1.
  - Each enabled channel is selected for exactly DWELL consecutive cycles, with no gap between channels.
- With N enabled channels:
  - busy is high for N×DWELL cycles.
  - done pulses in the first cycle after busy falls, with busy=0 in that cycle.
  - Earliest re-start is sampled in the cycle after done.
- mask=0: done pulses at T+1; busy never asserts.
- data_out has zero latency from data_in, gated by busy.
- Channel advance uses a priority search over the latched mask. The next channel index is computed combinationally and registered at the dwell boundary.

## Configuration
- `SCAN_LOOP_EN` defined:
  - After the highest enabled channel, the scan wraps to the lowest enabled channel with no idle cycle.
  - done pulses for one cycle coincident with the first cycle of each new pass, while busy stays 1.
  - The scan exits only on abort or reset.
- `SCAN_LOOP_EN` undefined: single pass as described above.

## Test plan
- DWELL=4, mask=8'h81, start at T:
  - ch=0 for T+1..T+4, then ch=7 for T+5..T+8.
  - done=1 only at T+9; busy=1 for T+1..T+8 only.
- mask=8'hFF, start at T:
  - ch steps 0,1,...,7, four cycles each.
  - busy high for 32 cycles; done at T+33.
  - data_out follows data_in exactly while busy, and is 0 otherwise.
- mask=8'h00, start at T: done=1 at T+1, busy never high, sel stays 000.
- mask=8'h24 with abort at T+3:
  - busy=0 and ch=0 from T+4.
  - No done pulse.
  - A subsequent start is accepted at T+5.
- rst_n driven low mid-scan, asynchronous to clk: busy, done, data_out and sel go to 0 before the next edge. A new start after reset release scans normally.
- With `SCAN_LOOP_EN`, mask=8'h06, DWELL=2:
  - ch sequence 1,1,2,2,1,1,2,2,... continuously.
  - done pulses at the start of each second and later pass.
  - abort returns to IDLE.
